// File: rtl/axis_buffer_pkg.sv
// ---------------------------------------------------------------------------
// axis_buffer_pkg
// Shared definitions for the stream buffer / register slice family.
//   EMPTY / HALF / FULL : 2-bit occupancy-state encoding. The code of each
//                         state equals the number of words it holds, so the
//                         state register can be exported as a level directly.
//   LEVEL_WIDTH         : width of the occupancy / state encoding.
// ---------------------------------------------------------------------------
package axis_buffer_pkg;

  localparam int LEVEL_WIDTH = 2;

  localparam logic [LEVEL_WIDTH-1:0] EMPTY = 2'd0;
  localparam logic [LEVEL_WIDTH-1:0] HALF  = 2'd1;
  localparam logic [LEVEL_WIDTH-1:0] FULL  = 2'd2;

endpackage : axis_buffer_pkg

// File: rtl/output_buffer.sv
// ---------------------------------------------------------------------------
// output_buffer
// Two-entry AXI4-Stream register slice. out_valid, out_data and in_ready are
// all driven straight from flops, so no combinational path crosses the block
// in either direction. Full throughput, one cycle of forward latency.
//
// Ports:
//   aclk       in   clock, rising edge
//   aresetn    in   synchronous active-low reset (control only)
//   in_data    in   upstream data  [DATA_WIDTH]
//   in_valid   in   upstream valid
//   in_ready   out  upstream ready (registered)
//   out_data   out  downstream data (registered) [DATA_WIDTH]
//   out_valid  out  downstream valid (registered)
//   out_ready  in   downstream ready
//   out_level  out  occupancy 0/1/2 (only with OUTPUT_BUFFER_LEVEL_EN)
//
// Build option:
//   OUTPUT_BUFFER_LEVEL_EN  when defined, exports the registered occupancy.
// ---------------------------------------------------------------------------
module output_buffer
  import axis_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
`ifdef OUTPUT_BUFFER_LEVEL_EN
  output logic [LEVEL_WIDTH-1:0] out_level,
`endif
  input  logic                   out_ready
);

  logic [LEVEL_WIDTH-1:0] state_reg;
  logic [LEVEL_WIDTH-1:0] state_next;

  logic                   in_ready_reg;
  logic                   in_ready_next;
  logic                   out_valid_reg;
  logic                   out_valid_next;

  logic [DATA_WIDTH-1:0]  out_data_reg;  // O
  logic [DATA_WIDTH-1:0]  skid_data_reg; // S

  logic                   accept;
  logic                   xfer;
  logic                   load_o_from_in;
  logic                   load_o_from_s;
  logic                   load_s;

  assign accept = in_valid & in_ready_reg;
  assign xfer   = out_valid_reg & out_ready;

  // State and handshake flops. The handshake outputs are registered copies
  // decoded from state_next, so they always agree with state_reg.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Next-state and datapath load selection.
  always_comb begin
    state_next     = state_reg;
    load_o_from_in = 1'b0;
    load_o_from_s  = 1'b0;
    load_s         = 1'b0;
    unique case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_o_from_in = 1'b1;
          state_next     = HALF;
        end
      end
      HALF: begin
        if (accept && xfer) begin
          load_o_from_in = 1'b1;
        end else if (accept) begin
          // O is still waiting downstream; park the new word in S.
          load_s     = 1'b1;
          state_next = FULL;
        end else if (xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (xfer) begin
          load_o_from_s = 1'b1;
          state_next    = HALF;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Output decode, evaluated on the upcoming state so the flops above
  // present the right values in the same cycle as the new state.
  always_comb begin
    in_ready_next  = (state_next != FULL);
    out_valid_next = (state_next != EMPTY);
  end

  // Data registers carry no reset; validity is tracked by the control path.
  always_ff @(posedge aclk) begin
    if (load_o_from_in) begin
      out_data_reg <= in_data;
    end else if (load_o_from_s) begin
      out_data_reg <= skid_data_reg;
    end
    if (load_s) begin
      skid_data_reg <= in_data;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

`ifdef OUTPUT_BUFFER_LEVEL_EN
  // State codes equal word counts, so the state flop is the occupancy.
  assign out_level = state_reg;
`endif

endmodule : output_buffer

// File: tb/tb_output_buffer.sv
// ---------------------------------------------------------------------------
// tb_output_buffer
// Self-checking bench for output_buffer. Directed scenarios with hand-computed
// expectations plus a randomized stream checked against a queue model.
// Define OUTPUT_BUFFER_LEVEL_EN to also check out_level.
// ---------------------------------------------------------------------------
module tb_output_buffer;

  localparam int DW = 32;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef OUTPUT_BUFFER_LEVEL_EN
  logic [1:0]    out_level;
`endif

  int n_checks;
  int n_errors;

  output_buffer #(.DATA_WIDTH(DW)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef OUTPUT_BUFFER_LEVEL_EN
    .out_level (out_level),
`endif
    .out_ready (out_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Check handshake outputs (and level, when present) against a model state.
  task automatic check_ctl(input string tag, input logic exp_ready,
                           input logic exp_valid, input logic [1:0] exp_level);
    check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, exp_ready});
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
`ifdef OUTPUT_BUFFER_LEVEL_EN
    check({tag, ".level"}, {62'd0, out_level}, {62'd0, exp_level});
`else
    if (exp_level > 2'd2) $display("note: bad level %0d", exp_level);
`endif
  endtask

  // Randomized-run model state
  logic [DW-1:0] exp_q[$];
  int            model_cnt;
  int            sent;
  int            rcvd;
  int            cycles;
  logic          hold_pending;
  logic [DW-1:0] hold_value;
  logic          acc;
  logic          xf;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    aresetn   = 1'b0;
    in_valid  = 1'b1;        // handshakes during reset must be discarded
    in_data   = 32'hDEAD;
    out_ready = 1'b1;

    // 1. Reset then idle
    step();
    step();
    check_ctl("reset", 1'b1, 1'b0, 2'd0);
    aresetn  = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_ctl($sformatf("idle%0d", i), 1'b1, 1'b0, 2'd0);
    end

    // 2. Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      check($sformatf("stream%0d.data", i), {32'd0, out_data}, i);
      check_ctl($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    step();
    check_ctl("stream_end", 1'b1, 1'b0, 2'd0);

    // 3. Backpressure fill and drain; level sequence 0,1,2,2,1,0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    check_ctl("bp_a", 1'b1, 1'b1, 2'd1);
    check("bp_a.data", {32'd0, out_data}, 64'hA);
    in_data = 32'hB;
    step();
    check_ctl("bp_full", 1'b0, 1'b1, 2'd2);
    check("bp_full.data", {32'd0, out_data}, 64'hA);
    in_valid = 1'b0;
    in_data  = 32'hC;
    step();
    check_ctl("bp_hold", 1'b0, 1'b1, 2'd2);
    check("bp_hold.data", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1;
    step();
    check_ctl("bp_drain1", 1'b1, 1'b1, 2'd1);
    check("bp_drain1.data", {32'd0, out_data}, 64'hB);
    step();
    check_ctl("bp_drain2", 1'b1, 1'b0, 2'd0);

    // 4. Random valid/ready, incrementing data, queue scoreboard
    model_cnt    = 0;
    sent         = 0;
    rcvd         = 0;
    cycles       = 0;
    hold_pending = 1'b0;
    hold_value   = '0;
    while ((rcvd < 10000) && (cycles < 60000)) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_data   = in_valid ? sent + 1 : $urandom;
      #1;
      check("rnd.in_ready", {63'd0, in_ready}, {63'd0, model_cnt < 2});
      check("rnd.out_valid", {63'd0, out_valid}, {63'd0, model_cnt > 0});
      if (hold_pending)
        check("rnd.stable", {32'd0, out_data}, {32'd0, hold_value});
      acc = in_valid && (model_cnt < 2);
      xf  = out_ready && (model_cnt > 0);
      if (xf) begin
        check("rnd.order", {32'd0, out_data}, {32'd0, exp_q[0]});
        void'(exp_q.pop_front());
        rcvd++;
      end
      hold_pending = (model_cnt > 0) && !out_ready;
      hold_value   = out_data;
      if (acc) begin
        exp_q.push_back(in_data);
        sent++;
      end
      model_cnt = model_cnt + (acc ? 1 : 0) - (xf ? 1 : 0);
      @(posedge aclk);
      #1;
      cycles++;
    end
    check("rnd.received", rcvd, 10000);
    check("rnd.leftover", exp_q.size(), 0);
    in_valid = 1'b0;

    // 5. Reset while FULL, with a handshake offered during reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    in_data = 32'h66;
    step();
    check_ctl("rst_full", 1'b0, 1'b1, 2'd2);
    aresetn  = 1'b0;
    in_data  = 32'h99;
    out_ready = 1'b1;
    step();
    check_ctl("rst_edge", 1'b1, 1'b0, 2'd0);
    aresetn  = 1'b1;
    in_data  = 32'h77;
    step();
    in_valid = 1'b0;
    check_ctl("post_rst", 1'b1, 1'b1, 2'd1);
    check("post_rst.data", {32'd0, out_data}, 64'h77);
    step();
    check_ctl("post_rst_drain", 1'b1, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_output_buffer
